// File: rtl/spring_controller.sv
// spring_controller: pinball plunger spring. It compresses while the key is held, gives one upward impulse on release, then settles.
// Latency: every output is a register and changes on the edge that samples startOfFrame; collision takes effect on the next edge.
// Backpressure: none. pause freezes all state. Optional auto-fire is enabled with macro SPRING_AUTO_FIRE_EN.
module spring_controller #(
  parameter int REST_TOP_LEFT_Y = 400,
  parameter int MAX_COMPRESS    = 32,
  parameter int SPEED_PER_PIXEL = 24,
  parameter int RELEASE_STEP    = 4,
  parameter int SETTLE_FRAMES   = 8,
  parameter int AUTOFIRE_HOLD   = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               reset_level,
  input  logic               key5IsPressed,
  input  logic               collisionBallSpring,
  output logic signed [31:0] springSpeedY,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         springState
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  // The settle and hold counters share one width, which is sized for the larger of the two limits.
  localparam int CNT_MAX = (SETTLE_FRAMES > AUTOFIRE_HOLD) ? SETTLE_FRAMES : AUTOFIRE_HOLD;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [5:0]       MAX_C    = 6'(MAX_COMPRESS);
  localparam logic [5:0]       STEP_C   = 6'(RELEASE_STEP);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_FRAMES);
  localparam logic [31:0]      SPEED_C  = 32'(SPEED_PER_PIXEL);
  localparam logic [10:0]      REST_C   = 11'(REST_TOP_LEFT_Y);

  state_t             state_q, state_d;
  logic [5:0]         comp_q, comp_d;
  logic signed [31:0] rel_q, rel_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic               deliv_q, deliv_d;
  logic signed [31:0] speed_q, speed_d;
  logic [10:0]        top_q, top_d;

`ifdef SPRING_AUTO_FIRE_EN
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(AUTOFIRE_HOLD);
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] hold_inc;
  assign hold_inc = hold_q + CNT_W'(1);
`endif

  // Release impulse for the current compression. Negative means upward.
  logic signed [31:0] fire_speed;
  logic [5:0]         comp_inc;
  logic [5:0]         comp_dec;

  assign fire_speed = -$signed(32'(comp_q) * SPEED_C);
  assign comp_inc   = (comp_q < MAX_C) ? comp_q + 6'd1 : comp_q;
  assign comp_dec   = (comp_q > STEP_C) ? comp_q - STEP_C : 6'd0;

  // Next-state and next-output logic. reset_level overrides pause, and pause overrides everything else.
  always_comb begin
    state_d  = state_q;
    comp_d   = comp_q;
    rel_d    = rel_q;
    settle_d = settle_q;
    deliv_d  = deliv_q;
`ifdef SPRING_AUTO_FIRE_EN
    hold_d   = hold_q;
`endif

    if (reset_level) begin
      state_d  = ST_IDLE;
      comp_d   = 6'd0;
      rel_d    = 32'sd0;
      settle_d = '0;
      deliv_d  = 1'b0;
`ifdef SPRING_AUTO_FIRE_EN
      hold_d   = '0;
`endif
    end else if (!pause) begin
      // A collision on any cycle, not only on frame cycles, uses up the impulse for this shot.
      if (state_q == ST_RELEASE && collisionBallSpring) begin
        deliv_d = 1'b1;
      end

      if (startOfFrame) begin
        case (state_q)
          ST_IDLE: begin
            if (key5IsPressed) begin
              state_d = ST_CHARGE;
              comp_d  = comp_inc;
              deliv_d = 1'b0;
            end
          end

          ST_CHARGE: begin
            if (key5IsPressed) begin
              comp_d = comp_inc;
`ifdef SPRING_AUTO_FIRE_EN
              if (comp_q == MAX_C) begin
                if (hold_inc >= HOLD_C) begin
                  state_d = ST_RELEASE;
                  rel_d   = fire_speed;
                  hold_d  = '0;
                end else begin
                  hold_d  = hold_inc;
                end
              end
`endif
            end else if (comp_q != 6'd0) begin
              state_d = ST_RELEASE;
              rel_d   = fire_speed;
`ifdef SPRING_AUTO_FIRE_EN
              hold_d  = '0;
`endif
            end else begin
              state_d = ST_IDLE;
`ifdef SPRING_AUTO_FIRE_EN
              hold_d  = '0;
`endif
            end
          end

          ST_RELEASE: begin
            comp_d = comp_dec;
            if (comp_dec == 6'd0) begin
              state_d  = ST_SETTLE;
              settle_d = SETTLE_C;
            end
          end

          ST_SETTLE: begin
            if (settle_q <= CNT_W'(1)) begin
              state_d  = ST_IDLE;
              settle_d = '0;
            end else begin
              settle_d = settle_q - CNT_W'(1);
            end
          end

          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    // Outputs come from the next state, so they change on the same edge as the state they describe.
    speed_d = (state_d == ST_RELEASE && !deliv_d) ? rel_d : 32'sd0;
    top_d   = REST_C + 11'(comp_d);
  end

  // State and output registers. Asynchronous reset clears any impulse that is in progress.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      comp_q   <= 6'd0;
      rel_q    <= 32'sd0;
      settle_q <= '0;
      deliv_q  <= 1'b0;
      speed_q  <= 32'sd0;
      top_q    <= REST_C;
`ifdef SPRING_AUTO_FIRE_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      comp_q   <= comp_d;
      rel_q    <= rel_d;
      settle_q <= settle_d;
      deliv_q  <= deliv_d;
      speed_q  <= speed_d;
      top_q    <= top_d;
`ifdef SPRING_AUTO_FIRE_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign springSpeedY = speed_q;
  assign topLeftY     = top_q;
  assign springState  = state_q;

endmodule

// File: doc/spring_controller.md
SPRING_CONTROLLER -- requirements
Module: spring_controller

Interface
REQ-001 Parameter REST_TOP_LEFT_Y, default 400, spring top edge Y in pixels at rest.
REQ-002 Parameter MAX_COMPRESS, default 32, maximum compression in pixels (1..63).
REQ-003 Parameter SPEED_PER_PIXEL, default 24, release speed in fixed-point speed units per compressed pixel.
REQ-004 Parameter RELEASE_STEP, default 4, pixels of compression recovered per frame during release.
REQ-005 Parameter SETTLE_FRAMES, default 8, frames of dead time after release.
REQ-006 Parameter AUTOFIRE_HOLD, default 16, frames at full compression before auto-fire (used only under REQ-030).
REQ-007 clk  in  1  system clock; the block's only clock.
REQ-008 resetN  in  1  asynchronous active-low reset.
REQ-009 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-010 pause  in  1  freezes all state while high.
REQ-011 reset_level  in  1  synchronous return to reset state.
REQ-012 key5IsPressed  in  1  debounced plunger key level.
REQ-013 collisionBallSpring  in  1  ball touching spring this cycle.
REQ-014 springSpeedY  out  32 signed (int)  vertical impulse to ball controller; negative = upward.
REQ-015 topLeftY  out  11 signed  spring top edge Y in pixels.
REQ-016 springState  out  2  IDLE=0, CHARGE=1, RELEASE=2, SETTLE=3.

Function
REQ-017 All state and outputs SHALL be registered; all transitions occur only on cycles with startOfFrame=1 and pause=0, except REQ-022.
REQ-018 topLeftY SHALL equal REST_TOP_LEFT_Y + compression (6-bit unsigned, 0..MAX_COMPRESS) at all times.
REQ-019 IDLE: compression=0, springSpeedY=0; key5IsPressed=1 at a frame -> CHARGE.
REQ-020 CHARGE: springSpeedY=0; each frame with key=1, compression increments by 1, saturating at MAX_COMPRESS; frame with key=0 and compression>0 -> RELEASE, latching releaseSpeed = -(compression*SPEED_PER_PIXEL) as 32-bit signed; key=0 with compression=0 -> IDLE.
REQ-021 RELEASE: springSpeedY = releaseSpeed from the cycle after entry; each frame compression -= RELEASE_STEP, saturating at 0; on the frame that reaches 0 -> SETTLE with settle counter = SETTLE_FRAMES.
REQ-022 RELEASE: collisionBallSpring=1 on any non-paused cycle SHALL set a delivered flag; from the next cycle springSpeedY=0 until RELEASE exits (impulse given once per shot); delivered clears on entering CHARGE.
REQ-023 SETTLE: springSpeedY=0, key ignored; counter decrements per frame; counter 1->0 -> IDLE.
REQ-024 pause=1 SHALL hold state, counters, compression and outputs unchanged, including discarding startOfFrame and collisionBallSpring.
REQ-025 reset_level=1 SHALL take priority over pause and startOfFrame and apply REQ-027 values on the next edge.
REQ-026 Key held through SETTLE into IDLE SHALL start a new CHARGE on the first IDLE frame.

Reset
REQ-027 resetN=0 SHALL asynchronously force springState=IDLE, compression=0, topLeftY=REST_TOP_LEFT_Y, springSpeedY=0, releaseSpeed=0, settle and hold counters=0, delivered=0.
REQ-028 Reset mid-RELEASE SHALL drop springSpeedY to 0 immediately, with no residual impulse after deassertion.

Configuration
REQ-029 Macro SPRING_AUTO_FIRE_EN selects auto-fire.
REQ-030 Defined: in CHARGE at compression=MAX_COMPRESS a hold counter counts frames with key=1; on reaching AUTOFIRE_HOLD the block enters RELEASE as if the key were released; counter clears on leaving CHARGE.
REQ-031 Undefined: no hold counter; CHARGE at MAX_COMPRESS persists indefinitely while key=1.

Verification
REQ-032 Key high 10 frames then low -> topLeftY 401..410, then RELEASE, springSpeedY=-240, topLeftY 406,402,400, SETTLE for 8 frames, IDLE.
REQ-033 Key high 50 frames (macro undefined) -> compression saturates at 32, topLeftY=432; release -> springSpeedY=-768.
REQ-034 collisionBallSpring pulse 2 cycles after RELEASE entry -> springSpeedY=-240 for those cycles, 0 from the next cycle onward.
REQ-035 pause high for 5 frames mid-CHARGE at compression 7 -> topLeftY stays 407, state stays CHARGE; resumes counting after pause drops.
REQ-036 resetN low mid-RELEASE -> outputs 0/400/IDLE asynchronously; reset_level pulse mid-SETTLE -> IDLE next edge.
REQ-037 SPRING_AUTO_FIRE_EN defined, key held -> RELEASE entered 16 frames after reaching compression 32, springSpeedY=-768 with key still high.
